// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file. Shares one registered write
// port between NUM_REQ valid/ready requesters (round-robin, optional fixed
// priority for requester 0) and runs a sweep that zeroes registers 1..31.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter bit          HIPRI_REQ0 = 1'b1
) (
  input  logic                    clock,
  input  logic                    ctrl_reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [5*NUM_REQ-1:0]    req_reg,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    ctrl_writeEnable,
  output logic [4:0]              ctrl_writeReg,
  output logic [31:0]             data_writeReg,
  output logic [7:0]              drop_count
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StArb, StClear} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [4:0]      clr_idx_q, clr_idx_d;
  logic            we_q, we_d;
  logic [4:0]      wreg_q, wreg_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [7:0]      drop_q, drop_d;

  logic            gnt_valid;
  logic            gnt_hipri;
  logic [PtrW-1:0] gnt_idx;
  logic [PtrW-1:0] cand_idx;
  logic [PtrW-1:0] rr_next;
  logic [4:0]      sel_reg;
  logic [31:0]     sel_data;
  logic            xfer;

  // Grant selection: requester 0 override first, then scan from rr_ptr.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_hipri = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    if (HIPRI_REQ0 && req_valid[0]) begin
      gnt_valid = 1'b1;
      gnt_hipri = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand_idx = PtrW'((32'(rr_ptr_q) + i) % NUM_REQ);
        if (!gnt_valid && req_valid[cand_idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand_idx;
        end
      end
    end
  end

  // One-hot ready; suppressed in reset and during the clear sweep.
  always_comb begin
    req_ready = '0;
    if (ctrl_reset && (state_q == StArb) && gnt_valid) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Mux the granted requester's address/data and compute the next rr pointer.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PtrW'(i)) begin
        sel_reg  = req_reg[5*i +: 5];
        sel_data = req_data[32*i +: 32];
      end
    end
    rr_next = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    xfer    = |(req_valid & req_ready);
  end

  // Next-state: arbitration/write stage in StArb, zeroing sweep in StClear.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    clr_idx_d = clr_idx_q;
    we_d      = 1'b0;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    drop_d    = drop_q;
    case (state_q)
      StArb: begin
        if (xfer) begin
          // Override grants to requester 0 must not disturb the rotation.
          if (!gnt_hipri) rr_ptr_d = rr_next;
          if (sel_reg == 5'd0) begin
            if (drop_q != 8'hff) drop_d = drop_q + 8'd1;
          end else begin
            we_d    = 1'b1;
            wreg_d  = sel_reg;
            wdata_d = sel_data;
          end
        end
        if (clear_start) state_d = StClear;
      end
      StClear: begin
        we_d    = 1'b1;
        wreg_d  = clr_idx_q;
        wdata_d = '0;
        if (clr_idx_q == 5'd31) begin
          state_d   = StArb;
          clr_idx_d = 5'd1;
        end else begin
          clr_idx_d = clr_idx_q + 5'd1;
        end
      end
      default: state_d = StArb;
    endcase
  end

  // State and registered write port.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q   <= StArb;
      rr_ptr_q  <= '0;
      clr_idx_q <= 5'd1;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      clr_idx_q <= clr_idx_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      drop_q    <= drop_d;
    end
  end

  assign clear_busy       = (state_q == StClear);
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign drop_count       = drop_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: one round-robin instance and one priority-override instance
// driven by the same requesters, checked against hand-computed values.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        ctrl_reset;
  logic [2:0]  req_valid;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic        clear_start;

  logic [2:0]  ready_rr, ready_hp;
  logic        busy_rr, busy_hp;
  logic        we_rr, we_hp;
  logic [4:0]  wreg_rr, wreg_hp;
  logic [31:0] wdata_rr, wdata_hp;
  logic [7:0]  drop_rr, drop_hp;

  int n_checks = 0;
  int n_fail   = 0;
  int we_hits;

  regfile_write_arbiter #(.NUM_REQ(3), .HIPRI_REQ0(1'b0)) dut_rr (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (ready_rr),
    .clear_start      (clear_start),
    .clear_busy       (busy_rr),
    .ctrl_writeEnable (we_rr),
    .ctrl_writeReg    (wreg_rr),
    .data_writeReg    (wdata_rr),
    .drop_count       (drop_rr)
  );

  regfile_write_arbiter #(.NUM_REQ(3), .HIPRI_REQ0(1'b1)) dut_hp (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (ready_hp),
    .clear_start      (clear_start),
    .clear_busy       (busy_hp),
    .ctrl_writeEnable (we_hp),
    .ctrl_writeReg    (wreg_hp),
    .data_writeReg    (wdata_hp),
    .drop_count       (drop_hp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 2 time units later.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    ctrl_reset  = 1'b0;
    clear_start = 1'b0;
    req_valid   = 3'b111;
    req_reg     = {5'd7, 5'd6, 5'd5};
    req_data    = {32'hC, 32'hB, 32'hA};

    // Reset state
    #2;
    check("rst_ready_rr", 32'(ready_rr), 32'h0);
    check("rst_ready_hp", 32'(ready_hp), 32'h0);
    check("rst_we", 32'(we_rr), 32'h0);
    check("rst_drop", 32'(drop_rr), 32'h0);
    check("rst_busy", 32'(busy_rr), 32'h0);
    repeat (2) tick();
    check("rst_we_held", 32'(we_hp), 32'h0);
    ctrl_reset = 1'b1;
    #1;
    check("rel_ready_rr", 32'(ready_rr), 32'h1);
    check("rel_ready_hp", 32'(ready_hp), 32'h1);

    // Round-robin 0,1,2 on dut_rr; dut_hp keeps granting requester 0
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rr_we", 32'(we_rr), 32'h1);
      check("rr_wreg", 32'(wreg_rr), 32'(5 + k));
      check("rr_wdata", wdata_rr, 32'(10 + k));
      check("hp_wreg", 32'(wreg_hp), 32'd5);
      check("hp_wdata", wdata_hp, 32'hA);
      if (k < 2) begin
        check("rr_ready", 32'(ready_rr), 32'(1 << (k + 1)));
        check("hp_ready", 32'(ready_hp), 32'h1);
      end
    end

    // Requester 0 drops: both instances alternate 1,2 with rr_ptr at 0
    req_valid = 3'b110;
    #1;
    check("alt_ready_rr0", 32'(ready_rr), 32'h2);
    check("alt_ready_hp0", 32'(ready_hp), 32'h2);
    for (int j = 0; j < 4; j++) begin
      int g;
      g = (j % 2 == 0) ? 1 : 2;
      tick();
      check("alt_wreg_rr", 32'(wreg_rr), 32'(5 + g));
      check("alt_wreg_hp", 32'(wreg_hp), 32'(5 + g));
      check("alt_wdata_hp", wdata_hp, 32'(10 + g));
      check("alt_ready_rr", 32'(ready_rr), (g == 1) ? 32'h4 : 32'h2);
      check("alt_ready_hp", 32'(ready_hp), (g == 1) ? 32'h4 : 32'h2);
    end

    // Writes to register 0 are accepted but dropped and counted
    req_valid        = 3'b010;
    req_reg[9:5]     = 5'd0;
    req_data[63:32]  = 32'hDEADBEEF;
    #1;
    check("r0_ready", 32'(ready_rr), 32'h2);
    we_hits = 0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (we_rr || we_hp) we_hits++;
      if (n == 10) check("r0_drop10", 32'(drop_rr), 32'd10);
    end
    check("r0_we_hits", 32'(we_hits), 32'd0);
    check("r0_drop_rr", 32'(drop_rr), 32'd255);
    check("r0_drop_hp", 32'(drop_hp), 32'd255);
    check("r0_hold_wreg", 32'(wreg_rr), 32'd7);
    check("r0_hold_wdata", wdata_rr, 32'hC);

    // Clear sweep started while requester 2 is valid
    req_valid   = 3'b100;
    clear_start = 1'b1;
    #1;
    check("clr_ready_start", 32'(ready_rr), 32'h4);
    tick();
    clear_start = 1'b0;
    check("clr_first_wreg", 32'(wreg_rr), 32'd7);
    check("clr_first_wdata", wdata_rr, 32'hC);
    for (int i = 1; i <= 31; i++) begin
      check("clr_busy", 32'(busy_rr), 32'h1);
      check("clr_ready", 32'(ready_rr), 32'h0);
      if (i == 5) clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      check("clr_we", 32'(we_rr), 32'h1);
      check("clr_wreg", 32'(wreg_rr), 32'(i));
      check("clr_wdata", wdata_rr, 32'h0);
    end
    check("clr_done_busy", 32'(busy_rr), 32'h0);
    check("clr_done_busy_hp", 32'(busy_hp), 32'h0);
    check("clr_done_ready", 32'(ready_rr), 32'h4);
    tick();
    check("clr_after_wreg", 32'(wreg_rr), 32'd7);
    check("clr_after_we", 32'(we_rr), 32'h1);

    // Reset in the middle of a sweep
    req_valid   = 3'b000;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (12) tick();
    check("mid_wreg12", 32'(wreg_rr), 32'd12);
    #1;
    ctrl_reset = 1'b0;
    #1;
    check("mid_we", 32'(we_rr), 32'h0);
    check("mid_busy", 32'(busy_rr), 32'h0);
    check("mid_wreg", 32'(wreg_rr), 32'h0);
    @(negedge clock);
    ctrl_reset = 1'b1;
    tick();
    check("mid_post_busy", 32'(busy_rr), 32'h0);
    check("mid_post_we", 32'(we_rr), 32'h0);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("restart_busy", 32'(busy_rr), 32'h1);
    tick();
    check("restart_we", 32'(we_rr), 32'h1);
    check("restart_wreg", 32'(wreg_rr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
